// File: rtl/text_terminal_writer.sv
// text_terminal_writer: turns UART bytes into text-buffer writes and owns the terminal cursor.
// Define CLEAR_ON_RESET_EN to sweep the whole screen with FILL_CHAR after every reset.
module text_terminal_writer #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic        i_Clk,
  input  logic        w_Reset,
  input  logic [7:0]  i_Byte,
  input  logic        i_Ready,
  output logic        o_Release,
  input  logic        i_Cursor_Left,
  input  logic        i_Cursor_Right,
  input  logic        i_Cursor_Down,
  output logic [11:0] o_Wr_Addr,
  output logic [7:0]  o_Wr_Data,
  output logic        o_Wr_En,
  output logic [11:0] o_Cursor,
  output logic        o_Busy
);
  localparam int TOTAL = COLS * ROWS;
  localparam int CW = $clog2(COLS);
  localparam logic [11:0] LAST = 12'(TOTAL - 1);
  localparam logic [11:0] ROW_STEP = 12'(COLS);
  localparam logic [11:0] LAST_ROW = 12'(TOTAL - COLS);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
`ifdef CLEAR_ON_RESET_EN
  localparam logic BOOT_CLEAR = 1'b1;
`else
  localparam logic BOOT_CLEAR = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WRITE, RELEASE, CLEAR} state_t;

  state_t          state_q, state_d;
  logic [11:0]     cursor_q, cursor_d, addr_q, addr_d;
  logic [CW-1:0]   col_q, col_d;
  logic [7:0]      byte_q, byte_d;
  logic            prev_ready_q, prev_ready_d, boot_q, boot_d;
  logic [11:0]     inc_cur, dec_cur, lf_cur, cr_cur;
  logic [CW-1:0]   inc_col, dec_col;
  logic            printable;

  // Column is tracked alongside the cursor so no divide is needed for CR.
  assign inc_cur = (cursor_q == LAST) ? '0 : cursor_q + 12'd1;
  assign inc_col = (col_q == LAST_COL) ? '0 : col_q + CW'(1);
  assign dec_cur = (cursor_q == '0) ? LAST : cursor_q - 12'd1;
  assign dec_col = (col_q == '0) ? LAST_COL : col_q - CW'(1);
  assign lf_cur = (cursor_q >= LAST_ROW) ? cursor_q - LAST_ROW : cursor_q + ROW_STEP;
  assign cr_cur = cursor_q - 12'(col_q);
  assign printable = !(byte_q inside {8'h00, 8'h08, 8'h0A, 8'h0C, 8'h0D});

  always_comb begin
    state_d = state_q;
    cursor_d = cursor_q;
    col_d = col_q;
    addr_d = addr_q;
    byte_d = byte_q;
    boot_d = boot_q;
    prev_ready_d = boot_q ? 1'b0 : i_Ready;
    case (state_q)
      IDLE:
        if (boot_q) begin
          state_d = CLEAR;
          addr_d = '0;
        end else if (i_Ready && !prev_ready_q) begin
          byte_d = i_Byte;
          state_d = WRITE;
        end else if (i_Cursor_Left) begin
          cursor_d = dec_cur;
          col_d = dec_col;
        end else if (i_Cursor_Right) begin
          cursor_d = inc_cur;
          col_d = inc_col;
        end else if (i_Cursor_Down) begin
          cursor_d = lf_cur;
        end
      WRITE: begin
        state_d = RELEASE;
        case (byte_q)
          8'h08: begin
            cursor_d = dec_cur;
            col_d = dec_col;
          end
          8'h0D: begin
            cursor_d = cr_cur;
            col_d = '0;
          end
          8'h0A: cursor_d = lf_cur;
          8'h0C: begin
            state_d = CLEAR;
            addr_d = '0;
          end
          8'h00: state_d = RELEASE;
          default: begin
            cursor_d = inc_cur;
            col_d = inc_col;
          end
        endcase
      end
      RELEASE: state_d = IDLE;
      CLEAR:
        if (addr_q == LAST) begin
          cursor_d = '0;
          col_d = '0;
          addr_d = '0;
          boot_d = 1'b0;
          state_d = boot_q ? IDLE : RELEASE;
        end else begin
          addr_d = addr_q + 12'd1;
        end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (w_Reset) begin
      state_q <= IDLE;
      cursor_q <= '0;
      col_q <= '0;
      addr_q <= '0;
      byte_q <= '0;
      prev_ready_q <= 1'b0;
      boot_q <= BOOT_CLEAR;
    end else begin
      state_q <= state_d;
      cursor_q <= cursor_d;
      col_q <= col_d;
      addr_q <= addr_d;
      byte_q <= byte_d;
      prev_ready_q <= prev_ready_d;
      boot_q <= boot_d;
    end
  end

  assign o_Wr_En = (state_q == WRITE && printable) || state_q == CLEAR;
  assign o_Wr_Addr = (state_q == CLEAR) ? addr_q : (state_q == WRITE && printable) ? cursor_q : '0;
  assign o_Wr_Data = (state_q == CLEAR) ? FILL_CHAR : (state_q == WRITE && printable) ? byte_q : '0;
  assign o_Release = state_q == RELEASE;
  assign o_Busy = state_q != IDLE;
  assign o_Cursor = cursor_q;
endmodule

// File: tb/tb_text_terminal_writer.sv
// tb_text_terminal_writer: directed vector table plus hand-written corner sequences.
module tb_text_terminal_writer;
  logic        clk = 0, rst = 1;
  logic [7:0]  i_byte = '0;
  logic        i_ready = 0, left = 0, right = 0, down = 0;
  logic        o_release, o_wr_en, o_busy;
  logic [11:0] o_wr_addr, o_cursor;
  logic [7:0]  o_wr_data;
  int total = 0, bad = 0;

  typedef struct {
    int downs, pre, b, nwr, a0, d0, lat, cur;
  } vec_t;
  vec_t tv [25];

  text_terminal_writer dut (
    .i_Clk(clk), .w_Reset(rst), .i_Byte(i_byte), .i_Ready(i_ready), .o_Release(o_release),
    .i_Cursor_Left(left), .i_Cursor_Right(right), .i_Cursor_Down(down),
    .o_Wr_Addr(o_wr_addr), .o_Wr_Data(o_wr_data), .o_Wr_En(o_wr_en),
    .o_Cursor(o_cursor), .o_Busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Watches from the cycle after acceptance until the release pulse (bounded).
  task automatic observe(input bit dn, output int nwr, output int a0, output int d0,
                         output int lat, output int cur, output int seq_ok);
    int pa;
    nwr = 0; a0 = -1; d0 = -1; lat = -1; cur = -1; seq_ok = 1; pa = 0;
    for (int c = 1; c <= 3000 && lat < 0; c++) begin
      @(negedge clk);
      down = dn && c == 1;
      if (!o_busy) seq_ok = 0;
      if (o_wr_en) begin
        if (nwr == 0) begin
          a0 = int'(o_wr_addr);
          d0 = int'(o_wr_data);
        end else if (int'(o_wr_addr) != pa + 1 || int'(o_wr_data) != d0) seq_ok = 0;
        pa = int'(o_wr_addr);
        nwr++;
      end
      if (o_release) begin
        lat = c;
        cur = int'(o_cursor);
      end
    end
    i_ready = 0;
    down = 0;
  endtask

  task automatic send(input string tag, input int b, input bit dn, input int e_nwr, input int e_a0,
                      input int e_d0, input int e_lat, input int e_cur);
    int nwr, a0, d0, lat, cur, ok;
    @(negedge clk);
    i_byte = 8'(b);
    i_ready = 1;
    observe(dn, nwr, a0, d0, lat, cur, ok);
    chk({tag, " write_count"}, nwr, e_nwr);
    if (e_nwr > 0) begin
      chk({tag, " first_addr"}, a0, e_a0);
      chk({tag, " first_data"}, d0, e_d0);
      chk({tag, " write_sequence"}, ok, 1);
    end
    chk({tag, " release_latency"}, lat, e_lat);
    chk({tag, " cursor"}, cur, e_cur);
    @(negedge clk);
    chk({tag, " back_idle"}, {o_release, o_busy, o_wr_en}, 0);
  endtask

  task automatic press(input bit l, input bit r, input bit d);
    @(negedge clk);
    left = l; right = r; down = d;
    @(negedge clk);
    left = 0; right = 0; down = 0;
    chk("button_no_strobe", {o_release, o_wr_en}, 0);
  endtask

  task automatic post_reset();
`ifdef CLEAR_ON_RESET_EN
    int n, rel, seen, done;
    n = 0; rel = 0; seen = 0; done = 0;
    for (int c = 0; c < 3000 && done == 0; c++) begin
      @(negedge clk);
      if (o_wr_en) n++;
      if (o_release) rel++;
      if (o_busy) seen = 1;
      else if (seen == 1) done = 1;
    end
    chk("boot_sweep_len", n, 2400);
    chk("boot_release", rel, 0);
    chk("boot_cursor", int'(o_cursor), 0);
`endif
  endtask

  initial begin
    int nwr, a0, d0, lat, cur, ok, found;
    tv[0] = '{0, 0, 'h41, 1, 0, 'h41, 2, 1};
    tv[1] = '{0, 0, 'h0D, 0, 0, 0, 2, 0};
    tv[2] = '{0, 0, 'h08, 0, 0, 0, 2, 2399};
    tv[3] = '{0, 0, 'h0A, 0, 0, 0, 2, 79};
    tv[4] = '{0, 0, 'h42, 1, 79, 'h42, 2, 80};
    tv[5] = '{0, 0, 'h0D, 0, 0, 0, 2, 80};
    tv[6] = '{0, 0, 'h00, 0, 0, 0, 2, 80};
    tv[7] = '{0, 0, 'h0C, 2400, 0, 'h20, 2402, 0};
    tv[8] = '{0, 0, 'h0A, 0, 0, 0, 2, 80};
    for (int k = 0; k < 5; k++) tv[9 + k] = '{0, 0, 'h61 + k, 1, 80 + k, 'h61 + k, 2, 81 + k};
    tv[14] = '{0, 0, 'h0A, 0, 0, 0, 2, 165};
    for (int k = 0; k < 5; k++) tv[15 + k] = '{0, 0, 'h66 + k, 1, 165 + k, 'h66 + k, 2, 166 + k};
    tv[20] = '{27, 2330, 'h0A, 0, 0, 0, 2, 10};
    tv[21] = '{0, 0, 'h0D, 0, 0, 0, 2, 0};
    tv[22] = '{0, 0, 'h08, 0, 0, 0, 2, 2399};
    tv[23] = '{0, 0, 'h5A, 1, 2399, 'h5A, 2, 0};
    tv[24] = '{0, 0, 'h7F, 1, 0, 'h7F, 2, 1};

    repeat (3) @(negedge clk);
    chk("reset_outputs", {o_release, o_wr_en, o_busy, o_wr_addr, o_wr_data, o_cursor}, 0);
    rst = 0;
    post_reset();

    for (int i = 0; i < 25; i++) begin
      for (int k = 0; k < tv[i].downs; k++) press(0, 0, 1);
      if (tv[i].downs > 0) chk($sformatf("vec%0d pre_cursor", i), int'(o_cursor), tv[i].pre);
      send($sformatf("vec%0d", i), tv[i].b, 0, tv[i].nwr, tv[i].a0, tv[i].d0, tv[i].lat, tv[i].cur);
    end

    repeat (4) press(0, 1, 0);
    chk("right_x4", int'(o_cursor), 5);
    press(1, 1, 0);
    chk("left_over_right", int'(o_cursor), 4);
    press(0, 1, 1);
    chk("right_over_down", int'(o_cursor), 5);
    send("down_in_write", 'h43, 1, 1, 5, 'h43, 2, 6);

    @(negedge clk);
    i_byte = 8'h0C;
    i_ready = 1;
    found = 0;
    for (int c = 0; c < 2000 && found == 0; c++) begin
      @(negedge clk);
      if (o_wr_en && o_wr_addr == 12'd1000) found = 1;
    end
    chk("sweep_reached_1000", found, 1);
    rst = 1;
    @(negedge clk);
    chk("midreset_idle", {o_busy, o_release, o_wr_en}, 0);
    chk("midreset_cursor", int'(o_cursor), 0);
    rst = 0;
    post_reset();
    observe(0, nwr, a0, d0, lat, cur, ok);
    chk("reaccept write_count", nwr, 2400);
    chk("reaccept first_addr", a0, 0);
    chk("reaccept first_data", d0, 'h20);
    chk("reaccept write_sequence", ok, 1);
    chk("reaccept release_seen", int'(lat > 0), 1);
    chk("reaccept cursor", cur, 0);
    @(negedge clk);
    chk("reaccept back_idle", {o_release, o_busy, o_wr_en}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/text_terminal_writer.md
Name: text_terminal_writer

Overview:
- Consumes received bytes from the UART decoder through its ready/release handshake and turns them into single-cycle write strobes on the VGA text buffer RAM write port.
- Owns the terminal cursor: printable characters, control codes (BS, CR, LF, FF), clear-screen sweep and button cursor moves.
- Sits between UART_Decoder and VGA_Text_Buffer. It exports the cursor index for the VGA renderer's highlight and for the seven-segment display.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen; TOTAL = COLS*ROWS = 2400 cells
FILL_CHAR, 8'h20, byte written by the clear sweep

Ports:
i_Clk  in  1  system clock
w_Reset  in  1  reset: synchronous, active-high, clocked by i_Clk
i_Byte  in  8  received byte; stable while i_Ready=1
i_Ready  in  1  decoder holds high until released
o_Release  out  1  one-cycle pulse; frees the decoder for the next byte
i_Cursor_Left  in  1  one-cycle button pulse
i_Cursor_Right  in  1  one-cycle button pulse
i_Cursor_Down  in  1  one-cycle button pulse
o_Wr_Addr  out  12  RAM write address
o_Wr_Data  out  8  RAM write data
o_Wr_En  out  1  RAM write strobe
o_Cursor  out  12  cursor cell index, 0..TOTAL-1
o_Busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values:
  - all outputs 0; state IDLE; cursor 0; internal column 0.
  - r_Prev_Ready is cleared to 0, so a byte still held by the decoder through reset is processed afterwards.
- Cursor bookkeeping:
  - cursor and column (0..COLS-1) are kept as separate registers and updated incrementally.
  - No multiply or divide in the datapath. Invariant: cursor mod COLS == column.
- States: IDLE, WRITE, RELEASE, CLEAR.
- Accept:
  - In IDLE, when i_Ready=1 and r_Prev_Ready=0 in cycle N: latch i_Byte and go to WRITE.
  - r_Prev_Ready samples i_Ready every cycle.
- WRITE (cycle N+1):
  - Printable byte (any value except 00,08,0A,0C,0D): o_Wr_En=1, o_Wr_Addr=cursor, o_Wr_Data=byte; next cursor = cursor+1, wrapping 2399->0; go to RELEASE.
  - 08 BS: cursor-1 (0->2399), no write, no erase; go to RELEASE.
  - 0D CR: cursor-column (start of the current row), no write; go to RELEASE.
  - 0A LF: cursor+COLS, wrapping modulo TOTAL (2320+80 -> 0+column); column unchanged; go to RELEASE.
  - 00 NUL: ignored, no write; go to RELEASE.
  - 0C FF: go to CLEAR with the sweep address at 0.
- RELEASE (cycle N+2):
  - o_Release=1 for exactly one cycle; the new o_Cursor is visible in this cycle.
  - Go to IDLE at N+3. Printable-byte latency: accept to release = 2 cycles.
- CLEAR:
  - One cell per cycle: o_Wr_En=1, o_Wr_Addr=0..2399 ascending, o_Wr_Data=FILL_CHAR. This is 2400 consecutive strobes.
  - After address 2399: cursor=0, column=0, go to RELEASE.
- Buttons:
  - Honoured only in IDLE, and only in a cycle where no byte is accepted. Otherwise the pulse is dropped.
  - Priority: Left > Right > Down.
  - Left = BS semantics. Right = +1 with wrap. Down = LF semantics.
  - Button moves take effect next cycle and never pulse o_Release or o_Wr_En.
- Handshake:
  - i_Ready rising during WRITE, RELEASE or CLEAR is ignored until IDLE.
  - The next acceptance needs i_Ready to go low after release and then rise again.
- Reset mid-operation:
  - Any state returns to IDLE next cycle; an in-progress sweep is aborted; no release is pulsed.
  - If i_Ready is still high, the byte is re-accepted in the first IDLE cycle after reset deasserts.
- o_Wr_En is never high for more than one cycle outside CLEAR.

Optional Feature:
CLEAR_ON_RESET_EN
- Defined: on the first cycle after w_Reset deasserts, the block enters CLEAR with no byte latched.
  - It sweeps all 2400 cells with FILL_CHAR, with o_Busy high.
  - It then returns to IDLE with cursor 0 and no o_Release pulse.
  - A pending i_Ready is accepted only after the sweep completes.
- Undefined: reset goes straight to IDLE and the RAM contents are left untouched.

Test Plan:
- Reset, then send 0x41 (i_Ready rises at N) -> o_Wr_En=1 at N+1 with addr 0, data 0x41; o_Release=1 at N+2; o_Cursor=1 at N+2.
- Cursor=79, send 0x42 then 0x0D -> write at addr 79; cursor goes to 80, then CR gives 80. Cursor=85, send 0x0A -> 165. Cursor=2330, send 0x0A -> 10.
- Cursor=0, send 0x08 -> cursor=2399, no write strobe. Then send 0x5A -> write at 2399, cursor wraps to 0.
- Send 0x0C -> exactly 2400 consecutive o_Wr_En cycles, addr 0..2399, data 0x20; a single o_Release after the sweep; cursor=0; o_Busy high throughout.
- Pulse i_Cursor_Left and i_Cursor_Right in the same cycle at cursor=5 in IDLE -> cursor=4. Pulse i_Cursor_Down during WRITE -> ignored.
- Assert w_Reset at sweep address 1000 while i_Ready stays high -> IDLE, cursor 0, no release; the FF is re-accepted and the sweep restarts at addr 0. With CLEAR_ON_RESET_EN: the reset sweep of 2400 strobes runs first, with no release pulse.
